// File: rtl/bsg_tag_packet_deser.sv
// Serial bsg_tag packet deserializer: start bit, header and payload LSB-first, stop bit.
// Received packets sit in a one-entry holding register that is released by yumi_i.
module bsg_tag_packet_deser #(
    parameter int header_width_p      = 4,
    parameter int max_payload_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           tdi_i,
    input  logic                           yumi_i,
    output logic                           v_o,
    output logic [header_width_p-1:0]      header_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           frame_err_o,
    output logic                           overrun_o
);

    // state   | meaning
    // IDLE    | waiting for a start bit
    // HEADER  | shifting in header bits
    // PAYLOAD | shifting in payload bits
    // STOP    | sampling the stop bit; 0 commits, 1 is a framing error
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, STOP} state_e;

    localparam int max_w_lp = (header_width_p > max_payload_width_p) ?
                              header_width_p : max_payload_width_p;
    localparam int cnt_w_lp = $clog2(max_w_lp + 1);
    localparam logic [cnt_w_lp-1:0] hdr_last_lp = cnt_w_lp'(header_width_p - 1);
    localparam logic [cnt_w_lp-1:0] pay_last_lp = cnt_w_lp'(max_payload_width_p - 1);

    state_e                         state_r, state_n;
    logic [cnt_w_lp-1:0]            cnt_r, cnt_n;
    logic [header_width_p-1:0]      hdr_sr_r, hdr_sr_n;
    logic [max_payload_width_p-1:0] pay_sr_r, pay_sr_n;
    logic [header_width_p:0]        hdr_shift;
    logic [max_payload_width_p:0]   pay_shift;
    logic                           commit, frame_err_n, accept;

    // New bits enter at the MSB so the first bit received lands in bit 0.
    assign hdr_shift = {tdi_i, hdr_sr_r};
    assign pay_shift = {tdi_i, pay_sr_r};

    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        hdr_sr_n    = hdr_sr_r;
        pay_sr_n    = pay_sr_r;
        commit      = 1'b0;
        frame_err_n = 1'b0;
        case (state_r)
            IDLE: begin
                if (tdi_i) begin
                    state_n = HEADER;
                    cnt_n   = '0;
                end
            end
            HEADER: begin
                hdr_sr_n = hdr_shift[header_width_p:1];
                if (cnt_r == hdr_last_lp) begin
                    state_n = PAYLOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                end
            end
            PAYLOAD: begin
                pay_sr_n = pay_shift[max_payload_width_p:1];
                if (cnt_r == pay_last_lp) begin
                    state_n = STOP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                end
            end
            STOP: begin
                state_n = IDLE;
                cnt_n   = '0;
                if (tdi_i) frame_err_n = 1'b1;
                else       commit      = 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            hdr_sr_r <= '0;
            pay_sr_r <= '0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            hdr_sr_r <= hdr_sr_n;
            pay_sr_r <= pay_sr_n;
        end
    end

    // A commit lands if the holding register is free or being emptied this cycle.
    assign accept = commit & (~v_o | yumi_i);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o         <= 1'b0;
            header_o    <= '0;
            payload_o   <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_err_n;
            overrun_o   <= commit & v_o & ~yumi_i;
            if (accept) begin
                v_o       <= 1'b1;
                header_o  <= hdr_sr_r;
                payload_o <= pay_sr_r;
            end else if (yumi_i) begin
                v_o <= 1'b0;
            end
        end
    end

endmodule
